// File: rtl/pe_pkg.sv
// ============================================================================
//  Module      : pe_pkg
//  Description : Shared defaults, FSM state encoding and width helpers for
//                the PE stream feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_CLR    = 3'd1,
    ST_FEED   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4
  } fsm_state_t;

  // Width able to hold a vector length in 0..max_k.
  function automatic int len_w(input int max_k);
    return $clog2(max_k + 1);
  endfunction

  // Width of a buffer address covering 0..max_k-1 (at least one bit).
  function automatic int addr_w(input int max_k);
    return (max_k > 1) ? $clog2(max_k) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_feeder_buf.sv
// ============================================================================
//  Module      : pe_feeder_buf
//  Description : MAX_K-deep act/wgt pair register file, one write port and
//                one asynchronous read port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_feeder_buf #(
  parameter int DATA_W = 8,
  parameter int MAX_K  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wact,
  input  logic [DATA_W-1:0] wwgt,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] ract,
  output logic [DATA_W-1:0] rwgt
);

  logic [DATA_W-1:0] r_act [MAX_K];
  logic [DATA_W-1:0] r_wgt [MAX_K];

  // Contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    if (we) begin
      r_act[waddr] <= wact;
      r_wgt[waddr] <= wwgt;
    end
  end

  assign ract = r_act[raddr];
  assign rwgt = r_wgt[raddr];

endmodule

`default_nettype wire

// File: rtl/pe_feeder.sv
// ============================================================================
//  Module      : pe_feeder
//  Description : Buffers one act/wgt vector, replays it into a systolic PE,
//                waits out the PE latency and returns the captured psum.
//                Optional psum self-check enabled by PE_FEEDER_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_feeder
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int MAX_K  = 16,
  parameter int PE_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_act,
  input  logic [DATA_W-1:0]        in_wgt,
  input  logic                     in_last,
  output logic [DATA_W-1:0]        act,
  output logic [DATA_W-1:0]        wgt,
  output logic                     acc_en,
  output logic                     acc_clr,
  input  logic [ACC_W-1:0]         psum_in,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ACC_W-1:0]         res_psum,
  output logic [len_w(MAX_K)-1:0]  res_len,
  output logic                     busy,
  output logic                     err
);

  localparam int c_CNT_W = len_w(MAX_K);
  localparam int c_ADR_W = addr_w(MAX_K);
  localparam int c_LAT_W = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  fsm_state_t           r_state;
  fsm_state_t           w_state_nxt;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_CNT_W-1:0]   r_len;
  logic [c_CNT_W-1:0]   r_idx;
  logic [c_LAT_W-1:0]   r_drain;
  logic [DATA_W-1:0]    r_act;
  logic [DATA_W-1:0]    r_wgt;
  logic                 r_acc_en;
  logic                 r_acc_clr;
  logic                 r_res_valid;
  logic [ACC_W-1:0]     r_res_psum;
  logic [c_CNT_W-1:0]   r_res_len;

  logic                 w_in_hs;
  logic                 w_last_beat;
  logic                 w_feed_done;
  logic                 w_drain_done;
  logic                 w_capture;
  logic                 w_res_hs;
  logic [c_ADR_W-1:0]   w_rd_idx;
  logic [DATA_W-1:0]    w_rd_act;
  logic [DATA_W-1:0]    w_rd_wgt;

  assign w_in_hs      = in_valid & (r_state == ST_LOAD);
  assign w_last_beat  = w_in_hs & (in_last | (r_count == c_CNT_W'(MAX_K - 1)));
  assign w_feed_done  = (r_idx == r_len - 1'b1);
  assign w_drain_done = (r_drain == c_LAT_W'(PE_LAT - 1));
  assign w_capture    = (r_state == ST_DRAIN) & w_drain_done;
  assign w_res_hs     = r_res_valid & res_ready;

  // Output registers are loaded one cycle ahead, so fetch the pair that the
  // next FEED cycle will present: entry 0 from CLR, idx+1 while feeding.
  assign w_rd_idx = (r_state == ST_CLR) ? '0 : c_ADR_W'(r_idx + 1'b1);

  pe_feeder_buf #(
    .DATA_W (DATA_W),
    .MAX_K  (MAX_K),
    .ADDR_W (c_ADR_W)
  ) u_buf (
    .clk   (clk),
    .we    (w_in_hs),
    .waddr (c_ADR_W'(r_count)),
    .wact  (in_act),
    .wwgt  (in_wgt),
    .raddr (w_rd_idx),
    .ract  (w_rd_act),
    .rwgt  (w_rd_wgt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:   if (w_last_beat)  w_state_nxt = ST_CLR;
      ST_CLR:                      w_state_nxt = ST_FEED;
      ST_FEED:   if (w_feed_done)  w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_drain_done) w_state_nxt = ST_RESULT;
      ST_RESULT: if (w_res_hs)     w_state_nxt = ST_LOAD;
      default:                     w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_drain     <= '0;
      r_act       <= '0;
      r_wgt       <= '0;
      r_acc_en    <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_psum  <= '0;
      r_res_len   <= '0;
    end else begin
      if (w_in_hs)                          r_count <= r_count + 1'b1;
      else if (w_res_hs)                    r_count <= '0;
      if (w_last_beat)                      r_len   <= r_count + 1'b1;
      if (r_state == ST_CLR)                r_idx   <= '0;
      else if (r_state == ST_FEED)          r_idx   <= r_idx + 1'b1;
      if (r_state == ST_DRAIN)              r_drain <= r_drain + 1'b1;
      else                                  r_drain <= '0;

      r_acc_clr <= (w_state_nxt == ST_CLR);
      r_acc_en  <= (w_state_nxt == ST_FEED);
      r_act     <= (w_state_nxt == ST_FEED) ? w_rd_act : '0;
      r_wgt     <= (w_state_nxt == ST_FEED) ? w_rd_wgt : '0;

      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_psum  <= psum_in;
        r_res_len   <= r_len;
      end else if (w_res_hs) begin
        r_res_valid <= 1'b0;
      end
    end
  end

`ifdef PE_FEEDER_CHECK_EN
  logic [ACC_W-1:0]      r_ref;
  logic                  r_err;
  logic [2*DATA_W-1:0]   w_prod;

  assign w_prod = $signed(r_act) * $signed(r_wgt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_acc_clr)
        r_ref <= '0;
      else if (r_acc_en)
        r_ref <= r_ref + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
      if (w_capture && (psum_in != r_ref))
        r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = (r_state == ST_LOAD);
  assign busy      = (r_state != ST_LOAD);
  assign act       = r_act;
  assign wgt       = r_wgt;
  assign acc_en    = r_acc_en;
  assign acc_clr   = r_acc_clr;
  assign res_valid = r_res_valid;
  assign res_psum  = r_res_psum;
  assign res_len   = r_res_len;

endmodule

`default_nettype wire

// File: tb/tb_pe_feeder.sv
// ============================================================================
//  Module      : tb_pe_feeder
//  Description : Self-checking bench for pe_feeder with a behavioural PE.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_feeder;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int MAX_K  = 16;
  localparam int PE_LAT = 1;
  localparam int LW     = $clog2(MAX_K + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_act = '0;
  logic [DATA_W-1:0] in_wgt = '0;
  logic              in_last = 1'b0;
  logic [DATA_W-1:0] act;
  logic [DATA_W-1:0] wgt;
  logic              acc_en;
  logic              acc_clr;
  logic [ACC_W-1:0]  psum_in;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [ACC_W-1:0]  res_psum;
  logic [LW-1:0]     res_len;
  logic              busy;
  logic              err;

  always #5 clk = ~clk;

  pe_feeder #(
    .DATA_W (DATA_W), .ACC_W (ACC_W), .MAX_K (MAX_K), .PE_LAT (PE_LAT)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready), .in_act (in_act),
    .in_wgt (in_wgt), .in_last (in_last),
    .act (act), .wgt (wgt), .acc_en (acc_en), .acc_clr (acc_clr),
    .psum_in (psum_in),
    .res_valid (res_valid), .res_ready (res_ready), .res_psum (res_psum),
    .res_len (res_len), .busy (busy), .err (err)
  );

  // Behavioural PE: single-cycle accumulator, psum visible the next cycle.
  logic [ACC_W-1:0] pe_acc;
  logic             force_zero = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pe_acc <= '0;
    else if (acc_clr) pe_acc <= '0;
    else if (acc_en)  pe_acc <= pe_acc + 32'(int'($signed(act)) * int'($signed(wgt)));
  end
  assign psum_in = force_zero ? '0 : pe_acc;

  // Record everything the feeder presents to the PE.
  byte fed_act[$];
  byte fed_wgt[$];
  int  clr_cnt = 0;
  always @(negedge clk) begin
    if (acc_en) begin
      fed_act.push_back(act);
      fed_wgt.push_back(wgt);
    end
    if (acc_clr) clr_cnt++;
  end

  int  n_vec = 0;
  int  n_err = 0;
  byte v_act[$];
  byte v_wgt[$];
  bit  exp_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present the first len beats of v_act/v_wgt; returns at the negedge after the last handshake.
  task automatic load_beats(input bit use_last, input bit gaps, output int len);
    int guard;
    len = (v_act.size() < MAX_K) ? v_act.size() : MAX_K;
    for (int i = 0; i < len; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_act   = v_act[i];
      in_wgt   = v_wgt[i];
      in_last  = use_last && (i == len - 1);
      guard = 0;
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        chk("load_timeout", 64'd1, 64'd0);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_vec(input bit use_last, input bit gaps, input int hold, input bit zero_psum);
    int len, lat, base_f, base_c, sum;
    logic [31:0] exp_psum;
    base_f = fed_act.size();
    base_c = clr_cnt;
    load_beats(use_last, gaps, len);
    sum = 0;
    for (int i = 0; i < len; i++) sum += int'(v_act[i]) * int'(v_wgt[i]);
    exp_psum = zero_psum ? 32'd0 : 32'(sum);
`ifdef PE_FEEDER_CHECK_EN
    if (zero_psum && sum != 0) exp_err = 1'b1;
`endif
    chk("in_ready_after_last", 64'(in_ready), 64'd0);
    lat = 0;
    while (!res_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(1 + len + PE_LAT));
    chk("res_psum", 64'(res_psum), 64'(exp_psum));
    chk("res_len", 64'(res_len), 64'(len));
    chk("clr_pulses", 64'(clr_cnt - base_c), 64'd1);
    chk("feed_beats", 64'(fed_act.size() - base_f), 64'(len));
    for (int i = 0; i < len && base_f + i < fed_act.size(); i++) begin
      chk("feed_act", 64'(fed_act[base_f + i]), 64'(v_act[i]));
      chk("feed_wgt", 64'(fed_wgt[base_f + i]), 64'(v_wgt[i]));
    end
    chk("err", 64'(err), 64'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_psum", 64'(res_psum), 64'(exp_psum));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("valid_after_hs", 64'(res_valid), 64'd0);
    chk("in_ready_after_hs", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int len, guard, n;
    bit ul;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_acc_en", 64'(acc_en), 64'd0);
    chk("rst_acc_clr", 64'(acc_clr), 64'd0);
    chk("rst_act_wgt", 64'({act, wgt}), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_psum", 64'(res_psum), 64'd0);
    chk("rst_res_len", 64'(res_len), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    v_act = '{3, 4, 5};   v_wgt = '{2, 2, 2};   run_vec(1, 0, 0, 0);
    v_act = '{-7};        v_wgt = '{9};         run_vec(1, 0, 0, 0);
    v_act = {};           v_wgt = {};
    for (int i = 0; i < MAX_K; i++) begin v_act.push_back(1); v_wgt.push_back(1); end
    run_vec(0, 0, 0, 0);
    v_act = '{1, 2};      v_wgt = '{3, 4};      run_vec(1, 0, 10, 0);
    v_act = '{1};         v_wgt = '{5};         run_vec(1, 0, 0, 0);

    // Reset in the middle of FEED.
    v_act = '{10, 20, 30, 40, 50, 60}; v_wgt = '{1, 1, 1, 1, 1, 1};
    load_beats(1, 0, len);
    guard = 0;
    while (!acc_en && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    chk("mid_feed_acc_en", 64'(acc_en), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    exp_err = 1'b0;
    chk("arst_acc_en", 64'(acc_en), 64'd0);
    chk("arst_acc_clr", 64'(acc_clr), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v_act = '{2};         v_wgt = '{3};         run_vec(1, 0, 0, 0);

`ifdef PE_FEEDER_CHECK_EN
    force_zero = 1'b1;
    v_act = '{2};         v_wgt = '{2};         run_vec(1, 0, 0, 1);
    force_zero = 1'b0;
    v_act = '{3};         v_wgt = '{3};         run_vec(1, 0, 0, 0);
`endif

    for (int t = 0; t < 25; t++) begin
      n = $urandom_range(1, MAX_K);
      v_act = {};
      v_wgt = {};
      for (int i = 0; i < n; i++) begin
        v_act.push_back(byte'($urandom_range(0, 255)));
        v_wgt.push_back(byte'($urandom_range(0, 255)));
      end
      ul = (n < MAX_K) ? 1'b1 : 1'($urandom_range(0, 1));
      run_vec(ul, 1, $urandom_range(0, 3), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
